// File: rtl/qber_popcnt_sched.sv
// Frame mismatch counter: XORs Alice/Bob word pairs, runs them through one shared popcount stage,
// accumulates per frame and flags totals above THRESH. Define QBER_SAT_EN for a saturating accumulator.
module qber_popcnt_sched #(
  parameter int unsigned WORDS  = 64,
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned THRESH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       a_data,
  input  logic [5:0]       b_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic             over_thr,
  output logic             done
);

  localparam int unsigned     WC_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [2:0]       pop_r_q, pop_r_d;
  logic             pop_v_q, pop_v_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             over_thr_q, over_thr_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             accept;

  function automatic logic [2:0] popcount6(input logic [5:0] x);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, x[i]};
    return n;
  endfunction

  assign accept = in_ready_q & in_valid;

`ifdef QBER_SAT_EN
  localparam int unsigned SUM_W = CNT_W + 1;
  logic [SUM_W-1:0] sum_wide;
  assign sum_wide = {1'b0, acc_q} + SUM_W'(pop_r_q);
`endif

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pop_r_d    = pop_r_q;
    pop_v_d    = 1'b0;
    acc_d      = acc_q;
    over_thr_d = over_thr_q;
    sat_d      = sat_q;

    // Accumulate stage: one add per valid popcount, in RUN and in DRAIN for the final beat.
    if (pop_v_q) begin
`ifdef QBER_SAT_EN
      if (sat_q || sum_wide[CNT_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_wide[CNT_W-1:0];
      end
`else
      acc_d = acc_q + CNT_W'(pop_r_q);
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = RUN;
          wcnt_d     = '0;
          pop_r_d    = '0;
          acc_d      = '0;
          over_thr_d = 1'b0;
          sat_d      = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          pop_r_d = popcount6(a_data ^ b_data);
          pop_v_d = 1'b1;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (wcnt_q == LAST_WORD) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d    = DONE;
        over_thr_d = (32'(acc_d) > THRESH) | sat_d;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops the frame: no done pulse and the partial result is discarded.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      wcnt_d     = '0;
      pop_v_d    = 1'b0;
      acc_d      = '0;
      over_thr_d = 1'b0;
      sat_d      = 1'b0;
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      pop_r_q    <= '0;
      pop_v_q    <= 1'b0;
      acc_q      <= '0;
      over_thr_q <= 1'b0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pop_r_q    <= pop_r_d;
      pop_v_q    <= pop_v_d;
      acc_q      <= acc_d;
      over_thr_q <= over_thr_d;
      sat_q      <= sat_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign err_count = acc_q;
  assign over_thr  = over_thr_q;
  assign done      = done_q;

endmodule
